// File: rtl/top_entity.sv
// top_entity: pitch/yaw gimbal bridge. An SPI mode-0 slave sets the PWM and H-bridge
// direction for two motor channels and reads back their quadrature encoder positions.
// TOP_ENTITY_STATUS_LEDS_EN: when defined, led1/led2 show the channel enables and
// led3 shows an active SPI transaction; otherwise the LEDs are tied low.
module top_entity #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned PWM_FREQ  = 20000,
    parameter int unsigned COUNTER_W = 12
) (
    input  logic clk,
    input  logic btn1,
    input  logic SPI_CLK,
    input  logic SPI_CS,
    input  logic SPI_PICO,
    output logic SPI_POCI,
    input  logic PITCH_ENC_A,
    input  logic PITCH_ENC_B,
    input  logic YAW_ENC_A,
    input  logic YAW_ENC_B,
    output logic PITCH_DIRA,
    output logic PITCH_DIRB,
    output logic PITCH_PWM_VAL,
    output logic YAW_DIRA,
    output logic YAW_DIRB,
    output logic YAW_PWM_VAL,
    output logic led1,
    output logic led2,
    output logic led3
);

    localparam int unsigned PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int unsigned PER_W  = $clog2(PERIOD);
    localparam int unsigned PROD_W = COUNTER_W + PER_W;
    localparam int unsigned SYNC_W = 7;
    // Synchronizer order {sclk, cs, pico, pa, pb, ya, yb}; CS resets inactive (high)
    localparam logic [SYNC_W-1:0] SYNC_RST = 7'b010_0000;

    logic [SYNC_W-1:0] meta_q, sync_q;
    logic              sclk_s, cs_s, pico_s;
    logic              sclk_p_q, cs_p_q;
    logic              sclk_rise_c, sclk_fall_c, cs_fall_c;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic        load_q, load_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  lo_q, lo_d;
    logic [63:0] snap_q, snap_d;
    logic [3:0]  left_q, left_d;
    logic [15:0] pitch_word_q, pitch_word_d;
    logic [15:0] yaw_word_q, yaw_word_d;
    logic [7:0]  rx_byte_c;

    logic [PER_W-1:0] cnt_q, p_thr_q, y_thr_q;
    logic             p_pwm_q, y_pwm_q, p_dira_q, p_dirb_q, y_dira_q, y_dirb_q;

    logic [3:0]  enc_prev_q;
    logic [31:0] pitch_pos_q, yaw_pos_q;

    // Duty-to-threshold scaling: (duty * PERIOD) >> COUNTER_W
    function automatic logic [PER_W-1:0] thr_of(input logic [COUNTER_W-1:0] duty);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(duty) * PROD_W'(PERIOD);
        return PER_W'(prod >> COUNTER_W);
    endfunction

    // x4 quadrature step: 00->10->11->01->00 is +1, reverse is -1, anything else 0
    function automatic logic [31:0] enc_step(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return 32'd1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: return 32'hFFFF_FFFF;
            default:                                return 32'd0;
        endcase
    endfunction

    // Two-flop synchronizers for all asynchronous inputs
    always_ff @(posedge clk) begin
        if (btn1) begin
            meta_q <= SYNC_RST;
            sync_q <= SYNC_RST;
        end else begin
            meta_q <= {SPI_CLK, SPI_CS, SPI_PICO, PITCH_ENC_A, PITCH_ENC_B, YAW_ENC_A, YAW_ENC_B};
            sync_q <= meta_q;
        end
    end

    assign sclk_s      = sync_q[6];
    assign cs_s        = sync_q[5];
    assign pico_s      = sync_q[4];
    assign sclk_rise_c = sclk_s & ~sclk_p_q;
    assign sclk_fall_c = ~sclk_s & sclk_p_q;
    assign cs_fall_c   = cs_p_q & ~cs_s;
    assign rx_byte_c   = {shift_q, pico_s};

    // SPI framing, command decode, word writes and read snapshot
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        load_d       = load_q;
        cmd_d        = cmd_q;
        lo_d         = lo_q;
        snap_d       = snap_q;
        left_d       = left_q;
        pitch_word_d = pitch_word_q;
        yaw_word_d   = yaw_word_q;
        if (cs_s || cs_fall_c) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
            tx_d       = 8'h00;
            load_d     = 1'b0;
            left_d     = 4'd0;
        end else if (sclk_rise_c) begin
            shift_d   = rx_byte_c[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                load_d = 1'b1;
                if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
                case (byte_cnt_q)
                    4'd0: begin
                        cmd_d  = rx_byte_c;
                        left_d = 4'd0;
                        case (rx_byte_c)
                            8'h20: begin snap_d = {pitch_pos_q, 32'h0};                 left_d = 4'd4; end
                            8'h21: begin snap_d = {yaw_pos_q, 32'h0};                   left_d = 4'd4; end
                            8'h22: begin snap_d = {pitch_pos_q, yaw_pos_q};             left_d = 4'd8; end
                            8'h30: begin snap_d = {pitch_word_q, yaw_word_q, 32'h0};    left_d = 4'd4; end
                            default: ;
                        endcase
                    end
                    4'd1, 4'd3: lo_d = {rx_byte_c[7:2], 2'b00};
                    4'd2: begin
                        if (cmd_q == 8'h10 || cmd_q == 8'h12) pitch_word_d = {rx_byte_c, lo_q};
                        else if (cmd_q == 8'h11)              yaw_word_d   = {rx_byte_c, lo_q};
                    end
                    4'd4: if (cmd_q == 8'h12) yaw_word_d = {rx_byte_c, lo_q};
                    default: ;
                endcase
            end
        end else if (sclk_fall_c) begin
            if (load_q) begin
                load_d = 1'b0;
                if (left_q != 4'd0) begin
                    tx_d   = snap_q[63:56];
                    snap_d = {snap_q[55:0], 8'h00};
                    left_d = left_q - 4'd1;
                end else begin
                    tx_d = 8'h00;
                end
            end else begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    // SPI state registers
    always_ff @(posedge clk) begin
        if (btn1) begin
            sclk_p_q     <= 1'b0;
            cs_p_q       <= 1'b1;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 4'd0;
            shift_q      <= 7'd0;
            tx_q         <= 8'h00;
            load_q       <= 1'b0;
            cmd_q        <= 8'h00;
            lo_q         <= 8'h00;
            snap_q       <= 64'd0;
            left_q       <= 4'd0;
            pitch_word_q <= 16'h0000;
            yaw_word_q   <= 16'h0000;
        end else begin
            sclk_p_q     <= sclk_s;
            cs_p_q       <= cs_s;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            load_q       <= load_d;
            cmd_q        <= cmd_d;
            lo_q         <= lo_d;
            snap_q       <= snap_d;
            left_q       <= left_d;
            pitch_word_q <= pitch_word_d;
            yaw_word_q   <= yaw_word_d;
        end
    end

    // PWM counter; thresholds refresh only at the period boundary
    always_ff @(posedge clk) begin
        if (btn1) begin
            cnt_q    <= '0;
            p_thr_q  <= '0;
            y_thr_q  <= '0;
            p_pwm_q  <= 1'b0;
            y_pwm_q  <= 1'b0;
            p_dira_q <= 1'b0;
            p_dirb_q <= 1'b0;
            y_dira_q <= 1'b0;
            y_dirb_q <= 1'b0;
        end else begin
            if (cnt_q == PER_W'(PERIOD - 1)) begin
                cnt_q   <= '0;
                p_thr_q <= thr_of(pitch_word_q[2 +: COUNTER_W]);
                y_thr_q <= thr_of(yaw_word_q[2 +: COUNTER_W]);
            end else begin
                cnt_q <= cnt_q + PER_W'(1);
            end
            p_pwm_q  <= pitch_word_q[15] && (cnt_q < p_thr_q);
            y_pwm_q  <= yaw_word_q[15] && (cnt_q < y_thr_q);
            p_dira_q <= pitch_word_q[15] & ~pitch_word_q[14];
            p_dirb_q <= pitch_word_q[15] &  pitch_word_q[14];
            y_dira_q <= yaw_word_q[15] & ~yaw_word_q[14];
            y_dirb_q <= yaw_word_q[15] &  yaw_word_q[14];
        end
    end

    // Quadrature position counters on the synchronized AB pairs
    always_ff @(posedge clk) begin
        if (btn1) begin
            enc_prev_q  <= 4'd0;
            pitch_pos_q <= 32'd0;
            yaw_pos_q   <= 32'd0;
        end else begin
            enc_prev_q  <= sync_q[3:0];
            pitch_pos_q <= pitch_pos_q + enc_step(enc_prev_q[3:2], sync_q[3:2]);
            yaw_pos_q   <= yaw_pos_q + enc_step(enc_prev_q[1:0], sync_q[1:0]);
        end
    end

    assign SPI_POCI      = tx_q[7];
    assign PITCH_DIRA    = p_dira_q;
    assign PITCH_DIRB    = p_dirb_q;
    assign PITCH_PWM_VAL = p_pwm_q;
    assign YAW_DIRA      = y_dira_q;
    assign YAW_DIRB      = y_dirb_q;
    assign YAW_PWM_VAL   = y_pwm_q;

`ifdef TOP_ENTITY_STATUS_LEDS_EN
    logic led1_q, led2_q, led3_q;

    // Status LEDs: channel enables and transaction-active
    always_ff @(posedge clk) begin
        if (btn1) begin
            led1_q <= 1'b0;
            led2_q <= 1'b0;
            led3_q <= 1'b0;
        end else begin
            led1_q <= pitch_word_q[15];
            led2_q <= yaw_word_q[15];
            led3_q <= ~cs_s;
        end
    end

    assign led1 = led1_q;
    assign led2 = led2_q;
    assign led3 = led3_q;
`else
    assign led1 = 1'b0;
    assign led2 = 1'b0;
    assign led3 = 1'b0;
`endif

endmodule

// File: tb/tb_top_entity.sv
// Self-checking bench for top_entity: directed gimbal scenarios followed by
// randomized SPI writes, encoder motion and reads against a behavioural model.
`timescale 1ns/1ps
module tb_top_entity;

    localparam int H      = 8;
    localparam int PERIOD = 1250;

    logic clk = 1'b0;
    logic btn1, SPI_CLK, SPI_CS, SPI_PICO, SPI_POCI;
    logic PITCH_ENC_A, PITCH_ENC_B, YAW_ENC_A, YAW_ENC_B;
    logic PITCH_DIRA, PITCH_DIRB, PITCH_PWM_VAL, YAW_DIRA, YAW_DIRB, YAW_PWM_VAL;
    logic led1, led2, led3;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  txb [16];
    logic [7:0]  rxb [16];
    logic [15:0] pw_m, yw_m;
    logic [31:0] ppos_m, ypos_m;
    logic [1:0]  pst, yst;

    always #20 clk = ~clk;

    top_entity dut (
        .clk(clk), .btn1(btn1),
        .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_PICO(SPI_PICO), .SPI_POCI(SPI_POCI),
        .PITCH_ENC_A(PITCH_ENC_A), .PITCH_ENC_B(PITCH_ENC_B),
        .YAW_ENC_A(YAW_ENC_A), .YAW_ENC_B(YAW_ENC_B),
        .PITCH_DIRA(PITCH_DIRA), .PITCH_DIRB(PITCH_DIRB), .PITCH_PWM_VAL(PITCH_PWM_VAL),
        .YAW_DIRA(YAW_DIRA), .YAW_DIRB(YAW_DIRB), .YAW_PWM_VAL(YAW_PWM_VAL),
        .led1(led1), .led2(led2), .led3(led3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic led_exp(input logic v);
`ifdef TOP_ENTITY_STATUS_LEDS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Position along the forward cycle 00,10,11,01
    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] enc_delta(input logic [1:0] p, input logic [1:0] c);
        int d;
        d = (gidx(c) - gidx(p) + 4) % 4;
        if (d == 1) return 32'd1;
        if (d == 3) return 32'hFFFF_FFFF;
        return 32'd0;
    endfunction

    function automatic int hi_exp(input logic [15:0] w);
        if (!w[15]) return 0;
        return (int'(w[13:2]) * PERIOD) / 4096;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        SPI_PICO = b;
        wait_clk(H);
        r = SPI_POCI;
        SPI_CLK = 1'b1;
        wait_clk(H);
        SPI_CLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic spi_txn(input int n);
        logic [7:0] r;
        SPI_CS = 1'b0;
        wait_clk(H);
        for (int k = 0; k < n; k++) begin
            spi_byte(txb[k], r);
            rxb[k] = r;
        end
        wait_clk(H);
        SPI_CS = 1'b1;
        wait_clk(H);
    endtask

    // Reference effect of a command frame of n bytes on the stored words
    task automatic model_write(input int n);
        if (n >= 3 && (txb[0] == 8'h10 || txb[0] == 8'h12)) pw_m = {txb[2], txb[1] & 8'hFC};
        if (n >= 3 && txb[0] == 8'h11)                      yw_m = {txb[2], txb[1] & 8'hFC};
        if (n >= 5 && txb[0] == 8'h12)                      yw_m = {txb[4], txb[3] & 8'hFC};
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int n);
        txb[0] = cmd; txb[1] = b1; txb[2] = b2; txb[3] = b3; txb[4] = b4;
        model_write(n);
        spi_txn(n);
    endtask

    task automatic move_enc(input logic [1:0] np, input logic [1:0] ny, input int hold);
        ppos_m = ppos_m + enc_delta(pst, np);
        ypos_m = ypos_m + enc_delta(yst, ny);
        pst = np;
        yst = ny;
        {PITCH_ENC_A, PITCH_ENC_B} = np;
        {YAW_ENC_A, YAW_ENC_B} = ny;
        wait_clk(hold);
    endtask

    task automatic check_pwm(input string tag);
        int ph, yh;
        ph = 0;
        yh = 0;
        wait_clk(2 * PERIOD + 8);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (PITCH_PWM_VAL) ph++;
            if (YAW_PWM_VAL) yh++;
        end
        chk({tag, "_pitch_hi"}, 64'(ph), 64'(hi_exp(pw_m)));
        chk({tag, "_yaw_hi"}, 64'(yh), 64'(hi_exp(yw_m)));
        chk({tag, "_dirs"}, 64'({PITCH_DIRA, PITCH_DIRB, YAW_DIRA, YAW_DIRB}),
            64'({pw_m[15] & ~pw_m[14], pw_m[15] & pw_m[14], yw_m[15] & ~yw_m[14], yw_m[15] & yw_m[14]}));
        chk({tag, "_leds"}, 64'({led1, led2}), 64'({led_exp(pw_m[15]), led_exp(yw_m[15])}));
    endtask

    task automatic check_status(input string tag);
        txb[0] = 8'h30;
        for (int k = 1; k < 5; k++) txb[k] = 8'h00;
        spi_txn(5);
        chk(tag, 64'({rxb[1], rxb[2], rxb[3], rxb[4]}), 64'({pw_m, yw_m}));
    endtask

    task automatic check_pos(input string tag);
        txb[0] = 8'h22;
        for (int k = 1; k < 9; k++) txb[k] = 8'h00;
        spi_txn(9);
        chk(tag, {rxb[1], rxb[2], rxb[3], rxb[4], rxb[5], rxb[6], rxb[7], rxb[8]}, {ppos_m, ypos_m});
    endtask

    initial begin
        logic       b;
        logic [7:0] r, c;
        int         n;
        pw_m = '0; yw_m = '0; ppos_m = '0; ypos_m = '0; pst = 2'b00; yst = 2'b00;
        btn1 = 1'b1; SPI_CLK = 1'b0; SPI_CS = 1'b1; SPI_PICO = 1'b0;
        PITCH_ENC_A = 1'b0; PITCH_ENC_B = 1'b0; YAW_ENC_A = 1'b0; YAW_ENC_B = 1'b0;
        wait_clk(20);
        chk("reset_outputs", 64'({SPI_POCI, PITCH_DIRA, PITCH_DIRB, PITCH_PWM_VAL, YAW_DIRA,
                                  YAW_DIRB, YAW_PWM_VAL, led1, led2, led3}), 64'd0);
        btn1 = 1'b0;
        wait_clk(5);
        check_pos("reset_pos22");

        // Pitch 50% forward, yaw 25% reverse
        do_write(8'h12, 8'h00, 8'hA0, 8'h00, 8'hD0, 5);
        check_pwm("wr12");
        check_status("status_after_wr12");

        // 123 forward cycles on pitch, 456 reverse cycles on yaw
        for (int i = 0; i < 123; i++) begin
            move_enc(2'b10, yst, 10); move_enc(2'b11, yst, 10);
            move_enc(2'b01, yst, 10); move_enc(2'b00, yst, 10);
        end
        for (int i = 0; i < 456; i++) begin
            move_enc(pst, 2'b01, 10); move_enc(pst, 2'b11, 10);
            move_enc(pst, 2'b10, 10); move_enc(pst, 2'b00, 10);
        end
        check_pos("pos_after_cycles");

        // Disable pitch
        do_write(8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 3);
        check_pwm("pitch_off");

        // Yaw write aborted after one data byte
        do_write(8'h11, 8'h5C, 8'h00, 8'h00, 8'h00, 2);
        check_status("abort_yaw_unchanged");
        check_status("after_abort_normal");

        // Transaction-active LED
        SPI_CS = 1'b0;
        wait_clk(6);
        chk("led3_active", 64'(led3), 64'(led_exp(1'b1)));
        SPI_CS = 1'b1;
        wait_clk(6);
        chk("led3_idle", 64'(led3), 64'd0);

        // CS rising mid-byte returns POCI to 0 and leaves state untouched
        do_write(8'h10, 8'h00, 8'hFC, 8'h00, 8'h00, 3);
        SPI_CS = 1'b0;
        wait_clk(H);
        spi_byte(8'h30, r);
        spi_bit(1'b0, b);
        spi_bit(1'b0, b);
        wait_clk(5);
        chk("midbyte_poci", 64'(SPI_POCI), 64'(pw_m[13]));
        SPI_CS = 1'b1;
        wait_clk(6);
        chk("poci_after_cs_rise", 64'(SPI_POCI), 64'd0);
        check_status("status_after_midbyte_abort");

        // Randomized word writes
        for (int t = 0; t < 5; t++) begin
            case ($urandom % 3)
                0:       c = 8'h10;
                1:       c = 8'h11;
                default: c = 8'h12;
            endcase
            n = (c == 8'h12) ? 5 : 3;
            do_write(c, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), n);
            check_pwm("rand_wr");
            check_status("rand_status");
        end

        // Randomized encoder motion, including no-change and double-bit jumps
        for (int t = 0; t < 200; t++)
            move_enc(2'($urandom), 2'($urandom), 3 + int'($urandom % 4));
        wait_clk(5);
        check_pos("rand_pos");

        // Unknown command: all-zero response and no side effects
        do begin
            c = 8'($urandom);
        end while (c == 8'h10 || c == 8'h11 || c == 8'h12 || c == 8'h20 ||
                   c == 8'h21 || c == 8'h22 || c == 8'h30);
        txb[0] = c;
        for (int k = 1; k < 7; k++) txb[k] = 8'($urandom);
        spi_txn(7);
        chk("unknown_cmd_resp", {8'h00, rxb[0], rxb[1], rxb[2], rxb[3], rxb[4], rxb[5], rxb[6]}, 64'd0);
        check_status("status_after_unknown");

        // Single-channel reads with bytes beyond the defined length
        txb[0] = 8'h20;
        for (int k = 1; k < 7; k++) txb[k] = 8'hFF;
        spi_txn(7);
        chk("read20_overrun", 64'({rxb[1], rxb[2], rxb[3], rxb[4], rxb[5], rxb[6]}), 64'({ppos_m, 16'h0000}));
        txb[0] = 8'h21;
        spi_txn(7);
        chk("read21_overrun", 64'({rxb[1], rxb[2], rxb[3], rxb[4], rxb[5], rxb[6]}), 64'({ypos_m, 16'h0000}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/top_entity.md
# top_entity

Top-level FPGA block for the pitch/yaw gimbal. It bridges an SPI slave command interface to two motor channels. Each channel has a PWM generator with H-bridge direction outputs and a quadrature encoder position counter. All logic runs on the single system clock; SPI and encoder inputs are asynchronous and synchronized internally.

## Interface
- CLK_FREQ, 25000000: system clock frequency in Hz.
- PWM_FREQ, 20000: PWM frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ clocks (1250 at defaults).
- COUNTER_W, 12: duty field width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- btn1  in  1  reset; synchronous, active-high.
- SPI_CLK  in  1  SPI mode-0 clock from master; asynchronous.
- SPI_CS  in  1  chip select, active low; asynchronous.
- SPI_PICO  in  1  master-to-slave data, MSB first.
- SPI_POCI  out  1  slave-to-master data, MSB first.
- PITCH_ENC_A, PITCH_ENC_B  in  1 each  pitch quadrature inputs.
- YAW_ENC_A, YAW_ENC_B  in  1 each  yaw quadrature inputs.
- PITCH_DIRA, PITCH_DIRB, PITCH_PWM_VAL  out  1 each  pitch H-bridge direction pins and PWM output.
- YAW_DIRA, YAW_DIRB, YAW_PWM_VAL  out  1 each  yaw H-bridge direction pins and PWM output.
- led1, led2, led3  out  1 each  status LEDs.

## Operation
- **Input synchronization:** SPI_CLK, SPI_CS, SPI_PICO and the encoder pins pass through 2-FF synchronizers. SPI_CLK edges are detected on the synchronized copy.
- **SPI framing:**
  - A transaction starts on the CS falling edge, which clears the bit count, byte count and tx register (tx = 0x00).
  - PICO is sampled on each SPI_CLK rising edge.
  - POCI = tx[7] at all times. On each SPI_CLK falling edge: if a byte has just completed, load tx with response byte[byte_index]; otherwise shift tx left.
  - Byte 0 is the command. Its response byte is 0x00.
- **Commands:**
  - 0x10: write pitch word.
  - 0x11: write yaw word.
  - 0x12: write pitch word, then yaw word.
  - 0x20: read pitch position (4 bytes).
  - 0x21: read yaw position (4 bytes).
  - 0x22: read pitch position, then yaw position (8 bytes).
  - 0x30: read PWM status (pitch word, then yaw word, 4 bytes).
  - Unknown commands, and bytes beyond the defined length, respond 0x00 and have no effect.
- **PWM word (16 bit):** bit15 = en, bit14 = dir, bits[13:2] = duty, bits[1:0] ignored (read back as 0).
  - Written words are sent low byte first.
  - A word takes effect on completion of its second byte. A partial word is discarded if CS rises.
- **Reads** are big-endian (MSB byte first).
  - Positions are 32-bit two's complement.
  - Status returns the stored 16-bit words.
  - Read data is snapshotted when the command byte completes.
- **PWM:**
  - Free-running counter 0..PERIOD-1.
  - threshold = (duty × PERIOD) >> COUNTER_W, computed when the word is written.
  - PWM_VAL = en && (counter < threshold).
  - en=0: DIRA = DIRB = 0. en=1, dir=0: DIRA=1, DIRB=0. en=1, dir=1: DIRA=0, DIRB=1.
- **Encoders (x4 decoding)** on the synchronized AB state:
  - 00→10→11→01→00 counts +1 per step.
  - The reverse sequence counts −1 per step.
  - No change, or a transition where both bits change, leaves the count unchanged.
  - The 32-bit counter wraps modulo 2^32.
- **LEDs:** led1 = pitch en, led2 = yaw en, led3 = SPI transaction active (synchronized CS low).

## Timing
- Reset state:
  - Outputs: SPI_POCI, all DIR/PWM outputs and LEDs are 0.
  - Internal state: PWM words 0x0000, positions 0, counters 0, SPI idle.
- Reset mid-transaction aborts it; SPI resumes at the next CS falling edge.
- Synchronizer latency is 2 clk, plus 1 clk for edge detection.
- POCI is valid no later than 4 clk after the SPI_CLK falling edge. Requires an SPI half-period ≥ 5 clk (200 ns at 25 MHz).
- Encoders: the position updates 3 clk after an input change. Each AB state must be held ≥ 3 clk.
- A new PWM threshold applies from the next counter cycle; the counter is not reset.
- CS rising edge mid-byte: the partial byte is discarded and POCI returns to 0.

## Configuration
- TOP_ENTITY_STATUS_LEDS_EN:
  - Defined: led1–led3 behave as described under Operation.
  - Undefined: led1–led3 are tied to 0 and the led logic is not built.

## Test plan
- Reset held 20 clk → all outputs 0; a 0x22 read returns eight 0x00 bytes.
- Write 0x12, 00 A0, 00 D0 → outputs: PITCH_DIRA=1, DIRB=0; YAW_DIRA=0, DIRB=1; pitch duty 50% (625/1250 clk high); yaw 25% (312 clk high).
- After the above write, read 0x30 → response bytes A0 00 D0 00.
- 123 CW cycles on pitch (10, 11, 01, 00; 10 clk each) and 456 CCW cycles on yaw → read 0x22 returns pitch 0x000001EC (+492) and yaw 0xFFFFF8E0 (−1824).
- Write 0x10 with 00 00 → pitch PWM and both pitch DIR outputs 0; led1 = 0.
- CS raised after 1 data byte of 0x11 → yaw word unchanged; the next transaction decodes normally.
